// File: rtl/vga_vram_arbiter.sv
// vga_vram_arbiter: single-port video RAM arbiter on the core clock.
//   Serves VGA pixel fetches (vram_rd/vram_addr -> vram_data/vram_vld, with
//   back-pressure on vram_busy) and a core-side pixel write port
//   (wr_valid/wr_addr/wr_data, handshake wr_ready) from one synchronous SRAM.
//   Reads have priority; after MAXRD consecutive reads with a write pending,
//   the write is forced through. Priority: forced write > read > clear > write.
// Optional clear engine (define VRAM_CLEAR_EN): clr_start/clr_color/clr_busy
//   fill addresses 0..DEPTH-1 with one colour in otherwise idle cycles.
// Ports:
//   clk_core, rst_core (async, active-low)
//   vram_rd, vram_addr, vram_busy, vram_data, vram_vld   pixel-fetch responder
//   wr_valid, wr_addr, wr_data, wr_ready                  pixel write port
//   sram_ce, sram_we, sram_addr, sram_wdata, sram_rdata   SRAM command/data
//   clr_start, clr_color, clr_busy                        clear (VRAM_CLEAR_EN)
module vga_vram_arbiter #(
  parameter int unsigned PWIDTH  = 8,
  parameter int unsigned AWIDTH  = 19,
  parameter int unsigned DEPTH   = 307200,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned MAXRD   = 8
) (
  input  logic              clk_core,
  input  logic              rst_core,
  input  logic              vram_rd,
  input  logic [AWIDTH-1:0] vram_addr,
  output logic              vram_busy,
  output logic [PWIDTH-1:0] vram_data,
  output logic              vram_vld,
  input  logic              wr_valid,
  input  logic [AWIDTH-1:0] wr_addr,
  input  logic [PWIDTH-1:0] wr_data,
  output logic              wr_ready,
  output logic              sram_ce,
  output logic              sram_we,
  output logic [AWIDTH-1:0] sram_addr,
  output logic [PWIDTH-1:0] sram_wdata,
  input  logic [PWIDTH-1:0] sram_rdata
`ifdef VRAM_CLEAR_EN
  ,
  input  logic              clr_start,
  input  logic [PWIDTH-1:0] clr_color,
  output logic              clr_busy
`endif
);

  localparam int unsigned SWIDTH = $clog2(MAXRD + 1);

  if (LATENCY < 1 || MAXRD < 1 || DEPTH < 1) begin : g_param_check
    $error("vga_vram_arbiter: LATENCY, MAXRD and DEPTH must be at least 1");
  end

  logic              rst_done;
  logic [SWIDTH-1:0] rd_streak;
  logic              forced_write;
  logic              read_accept;
  logic              write_accept;
  logic              clr_write;
  logic              clr_active;
  logic [AWIDTH-1:0] clr_addr;
  logic [PWIDTH-1:0] clr_col;
  logic [LATENCY:0]  rd_pipe;

  // Arbitration: a forced write pre-empts reads; otherwise reads win over
  // the clear engine, which in turn blocks the write port.
  assign forced_write = wr_valid & (rd_streak == SWIDTH'(MAXRD));
  assign vram_busy    = forced_write | ~rst_done;
  assign read_accept  = vram_rd & ~vram_busy;
  assign wr_ready     = rst_core & (forced_write | (~read_accept & ~clr_active));
  assign write_accept = wr_valid & wr_ready;
  assign clr_write    = clr_active & ~read_accept & ~forced_write;

  // Low for the first cycle after reset release so no read slips in early.
  always_ff @(posedge clk_core or negedge rst_core) begin
    if (!rst_core) rst_done <= 1'b0;
    else           rst_done <= 1'b1;
  end

  // Consecutive reads granted while a write is waiting; saturates at MAXRD.
  always_ff @(posedge clk_core or negedge rst_core) begin
    if (!rst_core) begin
      rd_streak <= '0;
    end else if (write_accept || !wr_valid) begin
      rd_streak <= '0;
    end else if (read_accept && (rd_streak != SWIDTH'(MAXRD))) begin
      rd_streak <= rd_streak + SWIDTH'(1);
    end
  end

`ifdef VRAM_CLEAR_EN
  localparam logic [0:0]        ST_IDLE   = 1'b0;
  localparam logic [0:0]        ST_CLEAR  = 1'b1;
  localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(DEPTH - 1);

  logic [0:0]        state;
  logic [0:0]        state_nxt;
  logic [AWIDTH-1:0] clr_addr_nxt;
  logic [PWIDTH-1:0] clr_col_nxt;

  // Clear engine state register.
  always_ff @(posedge clk_core or negedge rst_core) begin
    if (!rst_core) begin
      state    <= ST_IDLE;
      clr_addr <= '0;
      clr_col  <= '0;
    end else begin
      state    <= state_nxt;
      clr_addr <= clr_addr_nxt;
      clr_col  <= clr_col_nxt;
    end
  end

  // Clear engine next state; a new clr_start always restarts from address 0.
  always_comb begin
    state_nxt    = state;
    clr_addr_nxt = clr_addr;
    clr_col_nxt  = clr_col;
    if (clr_write) begin
      if (clr_addr == LAST_ADDR) state_nxt    = ST_IDLE;
      else                       clr_addr_nxt = clr_addr + AWIDTH'(1);
    end
    if (clr_start) begin
      state_nxt    = ST_CLEAR;
      clr_addr_nxt = '0;
      clr_col_nxt  = clr_color;
    end
  end

  assign clr_active = (state == ST_CLEAR);
  assign clr_busy   = clr_active;
`else
  assign clr_active = 1'b0;
  assign clr_addr   = '0;
  assign clr_col    = '0;
`endif

  // Register the granted access onto the SRAM command bus.
  always_ff @(posedge clk_core or negedge rst_core) begin
    if (!rst_core) begin
      sram_ce    <= 1'b0;
      sram_we    <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
    end else begin
      sram_ce <= read_accept | write_accept | clr_write;
      sram_we <= write_accept | clr_write;
      if (read_accept) begin
        sram_addr <= vram_addr;
      end else if (write_accept) begin
        sram_addr  <= wr_addr;
        sram_wdata <= wr_data;
      end else if (clr_write) begin
        sram_addr  <= clr_addr;
        sram_wdata <= clr_col;
      end
    end
  end

  // Read-valid pipeline: stage LATENCY lines up with sram_rdata of that read.
  always_ff @(posedge clk_core or negedge rst_core) begin
    if (!rst_core) begin
      rd_pipe   <= '0;
      vram_vld  <= 1'b0;
      vram_data <= '0;
    end else begin
      rd_pipe  <= {rd_pipe[LATENCY-1:0], read_accept};
      vram_vld <= rd_pipe[LATENCY];
      if (rd_pipe[LATENCY]) vram_data <= sram_rdata;
    end
  end

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Bench for vga_vram_arbiter: SRAM plant model plus a transaction-level
// reference (memory image, grant rules, return queue) driven per cycle.
module tb_vga_vram_arbiter;
  localparam int unsigned PW   = 8;
  localparam int unsigned AW   = 19;
  localparam int unsigned DEP  = 64;
  localparam int unsigned LAT  = 2;
  localparam int unsigned MAXR = 8;
`ifdef VRAM_CLEAR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  logic          clk_core = 1'b0;
  logic          rst_core;
  logic          vram_rd;
  logic [AW-1:0] vram_addr;
  logic          vram_busy;
  logic [PW-1:0] vram_data;
  logic          vram_vld;
  logic          wr_valid;
  logic [AW-1:0] wr_addr;
  logic [PW-1:0] wr_data;
  logic          wr_ready;
  logic          sram_ce;
  logic          sram_we;
  logic [AW-1:0] sram_addr;
  logic [PW-1:0] sram_wdata;
  logic [PW-1:0] sram_rdata;
`ifdef VRAM_CLEAR_EN
  logic          clr_start;
  logic [PW-1:0] clr_color;
  logic          clr_busy;
`endif

  always #5 clk_core = ~clk_core;

  vga_vram_arbiter #(
    .PWIDTH(PW), .AWIDTH(AW), .DEPTH(DEP), .LATENCY(LAT), .MAXRD(MAXR)
  ) dut (
    .clk_core   (clk_core),
    .rst_core   (rst_core),
    .vram_rd    (vram_rd),
    .vram_addr  (vram_addr),
    .vram_busy  (vram_busy),
    .vram_data  (vram_data),
    .vram_vld   (vram_vld),
    .wr_valid   (wr_valid),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .sram_ce    (sram_ce),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
`ifdef VRAM_CLEAR_EN
    ,
    .clr_start  (clr_start),
    .clr_color  (clr_color),
    .clr_busy   (clr_busy)
`endif
  );

  // Synchronous SRAM with LAT cycles from ce to rdata.
  logic [PW-1:0] plant_mem [0:1023];
  logic [PW-1:0] rpipe [0:LAT-1];
  always @(posedge clk_core) begin
    if (sram_ce && sram_we) plant_mem[sram_addr[9:0]] <= sram_wdata;
    if (sram_ce && !sram_we) rpipe[0] <= plant_mem[sram_addr[9:0]];
    for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
  end
  assign sram_rdata = rpipe[LAT-1];

  // Reference model state.
  typedef struct { int due; logic [PW-1:0] data; bit known; } ret_t;
  ret_t          rq[$];
  logic [PW-1:0] ref_mem [0:1023];
  bit            ref_known [0:1023];
  int            m_streak;
  bit            m_rel;
  bit            m_clr_active;
  int            m_clr_addr;
  logic [PW-1:0] m_clr_col;
  bit            m_ce, m_we, m_rd_acc, m_wr_acc;
  logic [AW-1:0] m_addr;
  logic [PW-1:0] m_wdata;

  logic          exp_busy, exp_ready, exp_vld, exp_ce, exp_we, exp_clr_busy;
  logic [PW-1:0] exp_data, exp_wdata;
  logic [AW-1:0] exp_addr;
  bit            exp_known;

  int ph;
  int checks;
  int errors;

  task automatic enter_reset();
    rst_core  = 1'b0;
    vram_rd   = 1'b0;
    vram_addr = '0;
    wr_valid  = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
`ifdef VRAM_CLEAR_EN
    clr_start = 1'b0;
    clr_color = '0;
`endif
    rq.delete();
    m_streak     = 0;
    m_clr_active = 1'b0;
    m_clr_addr   = 0;
    m_ce         = 1'b0;
    m_we         = 1'b0;
    m_addr       = '0;
    m_wdata      = '0;
    m_rel        = 1'b1;
  endtask

  task automatic leave_reset();
    repeat (2) @(negedge clk_core);
    @(posedge clk_core);
    #1 rst_core = 1'b1;
  endtask

  // One clock of stimulus; leaves exp_* holding the reference expectations
  // for the outputs visible at negedge+1 of this cycle.
  task automatic drive_cycle(input logic rd, input logic [AW-1:0] ra,
                             input logic wv, input logic [AW-1:0] wa,
                             input logic [PW-1:0] wd,
                             input logic cs, input logic [PW-1:0] cc);
    bit forced;
    bit clr_wr;
    @(negedge clk_core);
    ph++;
    exp_ce       = m_ce;
    exp_we       = m_we;
    exp_addr     = m_addr;
    exp_wdata    = m_wdata;
    exp_clr_busy = m_clr_active;
    if (rq.size() > 0 && rq[0].due == ph) begin
      exp_vld   = 1'b1;
      exp_data  = rq[0].data;
      exp_known = rq[0].known;
      void'(rq.pop_front());
    end else begin
      exp_vld   = 1'b0;
      exp_known = 1'b0;
    end
    vram_rd   = rd;
    vram_addr = ra;
    wr_valid  = wv;
    wr_addr   = wa;
    wr_data   = wd;
`ifdef VRAM_CLEAR_EN
    clr_start = cs;
    clr_color = cc;
`endif
    #1;
    forced    = wv && (m_streak == MAXR);
    exp_busy  = forced || m_rel;
    m_rd_acc  = rd && !exp_busy;
    exp_ready = forced || (!m_rd_acc && !m_clr_active);
    m_wr_acc  = wv && exp_ready;
    clr_wr    = m_clr_active && !m_rd_acc && !forced;
    m_ce      = m_rd_acc || m_wr_acc || clr_wr;
    m_we      = m_wr_acc || clr_wr;
    if (m_rd_acc) begin
      rq.push_back('{ph + 2 + LAT, ref_mem[ra[9:0]], ref_known[ra[9:0]]});
      m_addr = ra;
    end else if (m_wr_acc) begin
      ref_mem[wa[9:0]]   = wd;
      ref_known[wa[9:0]] = 1'b1;
      m_addr  = wa;
      m_wdata = wd;
    end else if (clr_wr) begin
      ref_mem[m_clr_addr]   = m_clr_col;
      ref_known[m_clr_addr] = 1'b1;
      m_addr  = AW'(m_clr_addr);
      m_wdata = m_clr_col;
    end
    if (m_wr_acc || !wv)  m_streak = 0;
    else if (m_rd_acc)    m_streak = (m_streak < MAXR) ? m_streak + 1 : MAXR;
    if (clr_wr) begin
      if (m_clr_addr == DEP - 1) m_clr_active = 1'b0;
      else                       m_clr_addr   = m_clr_addr + 1;
    end
    if (cs && CLR_EN) begin
      m_clr_active = 1'b1;
      m_clr_addr   = 0;
      m_clr_col    = cc;
    end
    m_rel = 1'b0;
  endtask

  task automatic test_reset();
    enter_reset();
    vram_rd  = 1'b1;
    wr_valid = 1'b1;
    @(negedge clk_core);
    #1;
    checks++;
    if (vram_busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b expected 1", vram_busy); end
    checks++;
    if (wr_ready !== 1'b0) begin errors++; $display("FAIL reset_wr_ready: got %b expected 0", wr_ready); end
    checks++;
    if ({vram_vld, vram_data} !== '0) begin errors++; $display("FAIL reset_vram_out: got vld=%b data=%0h expected 0", vram_vld, vram_data); end
    checks++;
    if ({sram_ce, sram_we, sram_addr, sram_wdata} !== '0) begin
      errors++; $display("FAIL reset_sram: got ce=%b we=%b addr=%0h wdata=%0h expected 0", sram_ce, sram_we, sram_addr, sram_wdata);
    end
`ifdef VRAM_CLEAR_EN
    checks++;
    if (clr_busy !== 1'b0) begin errors++; $display("FAIL reset_clr_busy: got %b expected 0", clr_busy); end
`endif
    vram_rd  = 1'b0;
    wr_valid = 1'b0;
    leave_reset();
    drive_cycle(1'b1, '0, 1'b0, '0, '0, 1'b0, '0);
    checks++;
    if (vram_busy !== 1'b1) begin errors++; $display("FAIL release_busy: got %b expected 1", vram_busy); end
    drive_cycle(1'b1, '0, 1'b0, '0, '0, 1'b0, '0);
    checks++;
    if (vram_busy !== 1'b0) begin errors++; $display("FAIL after_release_busy: got %b expected 0", vram_busy); end
    repeat (6) drive_cycle(1'b0, '0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic test_read_stream();
    drive_cycle(1'b0, '0, 1'b1, AW'(5), 8'hA3, 1'b0, '0);
    checks++;
    if (wr_ready !== 1'b1) begin errors++; $display("FAIL preload_ready: got %b expected 1", wr_ready); end
    drive_cycle(1'b1, AW'(5), 1'b0, '0, '0, 1'b0, '0);
    checks++;
    if (vram_busy !== 1'b0) begin errors++; $display("FAIL stream_accept: busy got %b expected 0", vram_busy); end
    for (int i = 1; i <= 6; i++) begin
      drive_cycle(1'b0, '0, 1'b0, '0, '0, 1'b0, '0);
      if (i == 1) begin
        checks++;
        if ({sram_ce, sram_we, sram_addr} !== {2'b10, AW'(5)}) begin
          errors++; $display("FAIL stream_sram_cmd: got ce=%b we=%b addr=%0h expected ce=1 we=0 addr=5", sram_ce, sram_we, sram_addr);
        end
      end
      checks++;
      if (vram_vld !== (i == 4)) begin errors++; $display("FAIL stream_vld_t%0d: got %b expected %b", i, vram_vld, (i == 4)); end
      if (i == 4) begin
        checks++;
        if (vram_data !== 8'hA3) begin errors++; $display("FAIL stream_data: got %0h expected a3", vram_data); end
      end
    end
  endtask

  task automatic test_starvation();
    logic pend;
    pend = 1'b1;
    drive_cycle(1'b0, '0, 1'b0, '0, '0, 1'b0, '0);
    for (int i = 1; i <= 12; i++) begin
      drive_cycle(1'b1, AW'(i), pend, AW'(32), 8'h5A, 1'b0, '0);
      checks++;
      if (vram_busy !== (i == 9)) begin errors++; $display("FAIL starve_busy_c%0d: got %b expected %b", i, vram_busy, (i == 9)); end
      checks++;
      if (wr_ready !== (i == 9)) begin errors++; $display("FAIL starve_ready_c%0d: got %b expected %b", i, wr_ready, (i == 9)); end
      if (i == 10) begin
        checks++;
        if ({sram_we, sram_addr, sram_wdata} !== {1'b1, AW'(32), 8'h5A}) begin
          errors++; $display("FAIL starve_sram_write: got we=%b addr=%0h wdata=%0h expected we=1 addr=20 wdata=5a", sram_we, sram_addr, sram_wdata);
        end
      end
      if (i == 9) pend = 1'b0;
    end
    repeat (6) drive_cycle(1'b0, '0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic test_collision();
    logic [PW-1:0] got[$];
    drive_cycle(1'b0, '0, 1'b1, AW'(256), 8'h11, 1'b0, '0);
    for (int i = 0; i < 10; i++) begin
      if (i == 0) begin
        drive_cycle(1'b1, AW'(256), 1'b1, AW'(256), 8'h22, 1'b0, '0);
        checks++;
        if ({vram_busy, wr_ready} !== 2'b00) begin
          errors++; $display("FAIL collide_grant: got busy=%b ready=%b expected 0 0", vram_busy, wr_ready);
        end
      end else if (i == 1) begin
        drive_cycle(1'b0, '0, 1'b1, AW'(256), 8'h22, 1'b0, '0);
        checks++;
        if (wr_ready !== 1'b1) begin errors++; $display("FAIL collide_retry: ready got %b expected 1", wr_ready); end
      end else if (i == 2) begin
        drive_cycle(1'b1, AW'(256), 1'b0, '0, '0, 1'b0, '0);
      end else begin
        drive_cycle(1'b0, '0, 1'b0, '0, '0, 1'b0, '0);
      end
      if (vram_vld === 1'b1) got.push_back(vram_data);
    end
    checks++;
    if (got.size() != 2) begin
      errors++; $display("FAIL collide_count: got %0d returns expected 2", got.size());
    end else begin
      checks++;
      if (got[0] !== 8'h11) begin errors++; $display("FAIL collide_old: got %0h expected 11", got[0]); end
      checks++;
      if (got[1] !== 8'h22) begin errors++; $display("FAIL collide_new: got %0h expected 22", got[1]); end
    end
  endtask

  task automatic test_ordering();
    logic [PW-1:0] dat[$];
    int            when[$];
    for (int i = 0; i < 16; i++) drive_cycle(1'b0, '0, 1'b1, AW'(i), PW'(i), 1'b0, '0);
    for (int j = 0; j < 24; j++) begin
      drive_cycle(j < 16, AW'(j), 1'b0, '0, '0, 1'b0, '0);
      if (vram_vld === 1'b1) begin dat.push_back(vram_data); when.push_back(j); end
    end
    checks++;
    if (dat.size() != 16) begin
      errors++; $display("FAIL order_count: got %0d pulses expected 16", dat.size());
    end else begin
      for (int n = 0; n < 16; n++) begin
        checks++;
        if (dat[n] !== PW'(n) || when[n] != 4 + n) begin
          errors++; $display("FAIL order_%0d: got data=%0h at %0d expected data=%0h at %0d", n, dat[n], when[n], n, 4 + n);
        end
      end
    end
  endtask

  task automatic test_reset_mid_read();
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, AW'(i), 1'b0, '0, '0, 1'b0, '0);
    drive_cycle(1'b0, '0, 1'b0, '0, '0, 1'b0, '0);
    #1;
    enter_reset();
    #1;
    checks++;
    if ({sram_ce, sram_we, sram_addr} !== '0) begin
      errors++; $display("FAIL midrst_sram: got ce=%b we=%b addr=%0h expected 0", sram_ce, sram_we, sram_addr);
    end
    checks++;
    if ({vram_busy, wr_ready, vram_vld} !== 3'b100) begin
      errors++; $display("FAIL midrst_ctrl: got busy=%b ready=%b vld=%b expected 1 0 0", vram_busy, wr_ready, vram_vld);
    end
    leave_reset();
    for (int i = 0; i < 10; i++) begin
      drive_cycle(1'b0, '0, 1'b0, '0, '0, 1'b0, '0);
      checks++;
      if (vram_vld !== 1'b0) begin errors++; $display("FAIL midrst_vld_c%0d: got %b expected 0", i, vram_vld); end
    end
  endtask

`ifdef VRAM_CLEAR_EN
  task automatic test_clear();
    int cnt;
    int bad;
    int nret;
    cnt = 0;
    drive_cycle(1'b0, '0, 1'b0, '0, '0, 1'b1, 8'h1C);
    for (int j = 1; j <= 200; j++) begin
      drive_cycle(1'b0, '0, 1'b0, '0, '0, 1'b0, '0);
      if (clr_busy === 1'b1) cnt++;
    end
    checks++;
    if (cnt != 64) begin errors++; $display("FAIL clear_idle_cycles: got %0d expected 64", cnt); end
    bad  = 0;
    nret = 0;
    for (int j = 0; j < 70; j++) begin
      drive_cycle(j < 64, AW'(j), 1'b0, '0, '0, 1'b0, '0);
      if (vram_vld === 1'b1) begin nret++; if (vram_data !== 8'h1C) bad++; end
    end
    checks++;
    if (nret != 64 || bad != 0) begin
      errors++; $display("FAIL clear_contents: got %0d returns with %0d wrong expected 64 with 0 wrong", nret, bad);
    end
    cnt = 0;
    drive_cycle(1'b0, '0, 1'b0, '0, '0, 1'b1, 8'h2D);
    for (int j = 1; j <= 300; j++) begin
      drive_cycle((j % 2) == 1, '0, 1'b0, '0, '0, 1'b0, '0);
      if (clr_busy === 1'b1) cnt++;
    end
    checks++;
    if (cnt != 128) begin errors++; $display("FAIL clear_shared_cycles: got %0d expected 128", cnt); end
  endtask
`endif

  task automatic test_random();
    logic          pend;
    logic [AW-1:0] wa;
    logic [PW-1:0] wd;
    logic          cs;
    pend = 1'b0;
    wa   = '0;
    wd   = '0;
    for (int i = 0; i < 16; i++) drive_cycle(1'b0, '0, 1'b1, AW'(i), PW'($urandom), 1'b0, '0);
    for (int n = 0; n < 500; n++) begin
      if (!pend && ($urandom % 3) == 0) begin
        pend = 1'b1;
        wa   = AW'($urandom % 16);
        wd   = PW'($urandom);
      end
      cs = CLR_EN && (($urandom % 200) == 0);
      drive_cycle(1'($urandom % 2), AW'($urandom % 16), pend, wa, wd, cs, PW'($urandom));
      if (m_wr_acc) pend = 1'b0;
      checks++;
      if (vram_busy !== exp_busy) begin errors++; $display("FAIL rand_busy ph=%0d: got %b expected %b", ph, vram_busy, exp_busy); end
      checks++;
      if (wr_ready !== exp_ready) begin errors++; $display("FAIL rand_ready ph=%0d: got %b expected %b", ph, wr_ready, exp_ready); end
      checks++;
      if (vram_vld !== exp_vld) begin errors++; $display("FAIL rand_vld ph=%0d: got %b expected %b", ph, vram_vld, exp_vld); end
      if (exp_vld && exp_known) begin
        checks++;
        if (vram_data !== exp_data) begin errors++; $display("FAIL rand_data ph=%0d: got %0h expected %0h", ph, vram_data, exp_data); end
      end
      checks++;
      if ({sram_ce, sram_we} !== {exp_ce, exp_we}) begin
        errors++; $display("FAIL rand_cmd ph=%0d: got ce=%b we=%b expected ce=%b we=%b", ph, sram_ce, sram_we, exp_ce, exp_we);
      end
      if (exp_ce) begin
        checks++;
        if (sram_addr !== exp_addr) begin errors++; $display("FAIL rand_addr ph=%0d: got %0h expected %0h", ph, sram_addr, exp_addr); end
      end
      if (exp_we) begin
        checks++;
        if (sram_wdata !== exp_wdata) begin errors++; $display("FAIL rand_wdata ph=%0d: got %0h expected %0h", ph, sram_wdata, exp_wdata); end
      end
`ifdef VRAM_CLEAR_EN
      checks++;
      if (clr_busy !== exp_clr_busy) begin errors++; $display("FAIL rand_clr_busy ph=%0d: got %b expected %b", ph, clr_busy, exp_clr_busy); end
`endif
    end
    repeat (8) drive_cycle(1'b0, '0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    ph     = 0;
    test_reset();
    test_read_stream();
    test_starvation();
    test_collision();
    test_ordering();
    test_reset_mid_read();
`ifdef VRAM_CLEAR_EN
    test_clear();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
